// File: rtl/ksa_pipelined_if.sv
// Operand/result handshake bundle for the pipelined Kogge-Stone adder.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface ksa_pipelined_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
endinterface

// File: rtl/ksa_pipelined.sv
// Kogge-Stone adder/subtractor: PG stage, one register per prefix level, then a sum stage,
// with per-stage valid bits and bubble-collapsing backpressure.
module ksa_pipelined #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  ksa_pipelined_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NumStg = LEVELS + 2;
  localparam int Last   = NumStg - 1;

  logic [WIDTH-1:0]  g_d    [LEVELS+1];
  logic [WIDTH-1:0]  g_q    [LEVELS+1];
  logic [WIDTH-1:0]  p_d    [LEVELS];
  logic [WIDTH-1:0]  p_q    [LEVELS];
  logic [WIDTH:0]    side_d [LEVELS+1];
  logic [WIDTH:0]    side_q [LEVELS+1];
  logic [NumStg-1:0] v_q, v_d, ld, vin;
  logic [WIDTH-1:0]  bx, hp, sum_d, sum_q;
  logic              cin_eff, am, bm, cout_d, cout_q, ovf_d, ovf_q, nxt;

  always_comb begin
    bx      = bus.Sub ? ~bus.B : bus.B;
    cin_eff = bus.Sub | bus.Cin;
    // Prefix index 0 is the carry-in as a bit -1 generate; index j stands for operand bit j-1.
    g_d[0]    = {bus.A[WIDTH-2:0] & bx[WIDTH-2:0], cin_eff};
    p_d[0]    = {bus.A[WIDTH-2:0] ^ bx[WIDTH-2:0], 1'b0};
    side_d[0] = {bus.A[WIDTH-1], bus.A ^ bx};
    for (int k = 1; k <= LEVELS; k++) begin
      g_d[k]    = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << (1 << (k - 1))));
      side_d[k] = side_q[k-1];
    end
    for (int k = 1; k < LEVELS; k++) begin
      p_d[k] = p_q[k-1] & (p_q[k-1] << (1 << (k - 1)));
    end
    // After the last level g_q[LEVELS][i] is the carry into bit i.
    hp     = side_q[LEVELS][WIDTH-1:0];
    am     = side_q[LEVELS][WIDTH];
    bm     = hp[WIDTH-1] ^ am;
    sum_d  = hp ^ g_q[LEVELS];
    cout_d = (am & bm) | (hp[WIDTH-1] & g_q[LEVELS][WIDTH-1]);
    ovf_d  = (am == bm) && (sum_d[WIDTH-1] != am);
  end

  // A stage loads when it is empty or the stage ahead of it moves.
  always_comb begin
    nxt      = ~v_q[Last] | bus.out_ready;
    ld       = '0;
    ld[Last] = nxt;
    for (int i = Last - 1; i >= 0; i--) begin
      nxt   = ~v_q[i] | nxt;
      ld[i] = nxt;
    end
    vin = {v_q[Last-1:0], bus.in_valid};
    v_d = (ld & vin) | (~ld & v_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i <= LEVELS; i++) begin
        g_q[i]    <= '0;
        side_q[i] <= '0;
      end
      for (int i = 0; i < LEVELS; i++) p_q[i] <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      v_q <= v_d;
      for (int i = 0; i <= LEVELS; i++) begin
        if (ld[i] && vin[i]) begin
          g_q[i]    <= g_d[i];
          side_q[i] <= side_d[i];
        end
      end
      for (int i = 0; i < LEVELS; i++) begin
        if (ld[i] && vin[i]) p_q[i] <= p_d[i];
      end
      if (ld[Last] && vin[Last]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign bus.in_ready  = rst_n & ld[0];
  assign bus.out_valid = v_q[Last];
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_ksa_pipelined.sv
// Bench for ksa_pipelined: directed vectors and backpressure/reset scenarios at WIDTH=32,
// plus random handshake streams on WIDTH=8 and WIDTH=24 builds.
module tb_ksa_pipelined;
  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n_rand = 1'b0;
  logic done8 = 1'b0;
  logic done24 = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_emit = 0;
  int   last_lat = 0;
  exp_t exp32_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ksa_pipelined_if #(.WIDTH(32)) bus32 ();
  ksa_pipelined_if #(.WIDTH(8))  bus8 ();
  ksa_pipelined_if #(.WIDTH(24)) bus24 ();

  ksa_pipelined #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n),      .bus(bus32));
  ksa_pipelined #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n_rand), .bus(bus8));
  ksa_pipelined #(.WIDTH(24)) u_dut24 (.clk(clk), .rst_n(rst_n_rand), .bus(bus24));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Plain wide arithmetic reference: {ovf, cout, sum}.
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input logic su);
    logic [63:0] m, aa, bb, s;
    logic [64:0] t;
    m  = (64'd1 << w) - 64'd1;
    aa = a & m;
    bb = (su ? ~b : b) & m;
    t  = {1'b0, aa} + {1'b0, bb} + {64'd0, su | ci};
    s  = t[63:0] & m;
    return {(aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]), t[w], s};
  endfunction

  task automatic push32(input logic [65:0] r);
    exp_t e;
    e.s   = r[63:0];
    e.co  = r[64];
    e.ov  = r[65];
    e.cyc = cyc + 1;
    exp32_q.push_back(e);
    n_acc++;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance, valid left high.
  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic su, input logic [65:0] r);
    bus32.in_valid = 1'b1;
    bus32.A = a;
    bus32.B = b;
    bus32.Cin = ci;
    bus32.Sub = su;
    for (int t = 0; t < 200; t++) begin
      #4;
      if (bus32.in_ready) begin
        push32(r);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("send32_timeout", {63'd0, bus32.in_ready}, 64'd1);
  endtask

  task automatic drain32();
    for (int t = 0; t < 100 && exp32_q.size() != 0; t++) @(negedge clk);
    check("drain32", exp32_q.size(), 0);
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic su, input logic [65:0] r);
    send32(a, b, ci, su, r);
    bus32.in_valid = 1'b0;
    drain32();
    check("latency32", last_lat, 7);
  endtask

  // Output monitor for the 32-bit DUT: ordering, values and stall stability.
  initial begin : mon32
    exp_t e;
    logic stall_prev;
    logic [31:0] prev_sum;
    logic prev_co, prev_ov;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (stall_prev) begin
        check("hold_valid", {63'd0, bus32.out_valid}, 64'd1);
        check("hold_sum", {32'd0, bus32.Sum}, {32'd0, prev_sum});
        check("hold_cout", {63'd0, bus32.Cout}, {63'd0, prev_co});
        check("hold_ovf", {63'd0, bus32.Ovf}, {63'd0, prev_ov});
      end
      if (rst_n && bus32.out_valid && bus32.out_ready) begin
        if (exp32_q.size() == 0) begin
          check("spurious32", {63'd0, bus32.out_valid}, 64'd0);
        end else begin
          e = exp32_q.pop_front();
          check("sum32", {32'd0, bus32.Sum}, e.s);
          check("cout32", {63'd0, bus32.Cout}, {63'd0, e.co});
          check("ovf32", {63'd0, bus32.Ovf}, {63'd0, e.ov});
          last_lat = cyc - e.cyc + 1;
          n_emit++;
        end
      end
      stall_prev = rst_n && bus32.out_valid && !bus32.out_ready;
      prev_sum = bus32.Sum;
      prev_co  = bus32.Cout;
      prev_ov  = bus32.Ovf;
    end
  end

  initial begin : rnd8
    exp_t q8[$];
    exp_t e;
    logic [65:0] r;
    int acc, minlat, budget;
    logic pend;
    acc = 0; minlat = 1000; budget = 0; pend = 1'b0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0; bus8.Sub = 1'b0;
    wait (rst_n_rand === 1'b1);
    @(negedge clk);
    while ((acc < 10000 || q8.size() != 0) && budget < 60000) begin
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        bus8.A = 8'($urandom);
        bus8.B = 8'($urandom);
        bus8.Cin = 1'($urandom);
        bus8.Sub = 1'($urandom);
        bus8.in_valid = (acc < 10000) && ($urandom_range(0, 3) != 0);
      end
      #4;
      if (bus8.out_valid && bus8.out_ready) begin
        if (q8.size() == 0) begin
          check("w8_spurious", {63'd0, bus8.out_valid}, 64'd0);
        end else begin
          e = q8.pop_front();
          check("w8_sum", {56'd0, bus8.Sum}, e.s);
          check("w8_cout", {63'd0, bus8.Cout}, {63'd0, e.co});
          check("w8_ovf", {63'd0, bus8.Ovf}, {63'd0, e.ov});
          if (cyc - e.cyc + 1 < minlat) minlat = cyc - e.cyc + 1;
        end
      end
      if (bus8.in_valid && bus8.in_ready) begin
        r = ref_add(8, {56'd0, bus8.A}, {56'd0, bus8.B}, bus8.Cin, bus8.Sub);
        e.s = r[63:0]; e.co = r[64]; e.ov = r[65]; e.cyc = cyc + 1;
        q8.push_back(e);
        acc++;
        pend = 1'b0;
      end else begin
        pend = bus8.in_valid;
      end
      budget++;
      @(negedge clk);
    end
    check("w8_beats", acc, 10000);
    check("w8_min_latency", minlat, 5);
    done8 = 1'b1;
  end

  initial begin : rnd24
    exp_t q24[$];
    exp_t e;
    logic [65:0] r;
    int acc, minlat, budget;
    logic pend;
    acc = 0; minlat = 1000; budget = 0; pend = 1'b0;
    bus24.in_valid = 1'b0; bus24.out_ready = 1'b0;
    bus24.A = '0; bus24.B = '0; bus24.Cin = 1'b0; bus24.Sub = 1'b0;
    wait (rst_n_rand === 1'b1);
    @(negedge clk);
    while ((acc < 10000 || q24.size() != 0) && budget < 60000) begin
      bus24.out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        bus24.A = 24'($urandom);
        bus24.B = 24'($urandom);
        bus24.Cin = 1'($urandom);
        bus24.Sub = 1'($urandom);
        bus24.in_valid = (acc < 10000) && ($urandom_range(0, 3) != 0);
      end
      #4;
      if (bus24.out_valid && bus24.out_ready) begin
        if (q24.size() == 0) begin
          check("w24_spurious", {63'd0, bus24.out_valid}, 64'd0);
        end else begin
          e = q24.pop_front();
          check("w24_sum", {40'd0, bus24.Sum}, e.s);
          check("w24_cout", {63'd0, bus24.Cout}, {63'd0, e.co});
          check("w24_ovf", {63'd0, bus24.Ovf}, {63'd0, e.ov});
          if (cyc - e.cyc + 1 < minlat) minlat = cyc - e.cyc + 1;
        end
      end
      if (bus24.in_valid && bus24.in_ready) begin
        r = ref_add(24, {40'd0, bus24.A}, {40'd0, bus24.B}, bus24.Cin, bus24.Sub);
        e.s = r[63:0]; e.co = r[64]; e.ov = r[65]; e.cyc = cyc + 1;
        q24.push_back(e);
        acc++;
        pend = 1'b0;
      end else begin
        pend = bus24.in_valid;
      end
      budget++;
      @(negedge clk);
    end
    check("w24_beats", acc, 10000);
    check("w24_min_latency", minlat, 7);
    done24 = 1'b1;
  end

  initial begin : main
    logic [31:0] sa [20];
    logic [31:0] sb [20];
    logic        sci [20];
    logic        ssu [20];
    int i, base;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
    bus32.A = '0; bus32.B = '0; bus32.Cin = 1'b0; bus32.Sub = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sa[k] = $urandom; sb[k] = $urandom; sci[k] = 1'($urandom); ssu[k] = k[0];
    end

    repeat (3) @(negedge clk);
    #4;
    check("rst_in_ready", {63'd0, bus32.in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, bus32.out_valid}, 64'd0);
    check("rst_sum", {32'd0, bus32.Sum}, 64'd0);
    check("rst_cout_ovf", {62'd0, bus32.Cout, bus32.Ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rst_n_rand = 1'b1;
    #4;
    check("release_in_ready", {63'd0, bus32.in_ready}, 64'd1);
    @(negedge clk);
    bus32.out_ready = 1'b1;

    // Hand-computed vectors, arguments: A, B, Cin, Sub, {Ovf, Cout, Sum}.
    run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 64'h0000_0000});
    run_one(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, {1'b0, 1'b0, 64'h9999_999A});
    run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 64'h8000_0000});
    run_one(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFE});
    run_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 64'h7FFF_FFFF});
    // Back-to-back pair: Cin ignored under Sub, and all-ones plus carry-in.
    send32(32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, {1'b0, 1'b1, 64'h0000_0000});
    send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, {1'b0, 1'b1, 64'hFFFF_FFFF});
    bus32.in_valid = 1'b0;
    drain32();
    check("latency32_b2b", last_lat, 7);

    // 20-beat stream with a 10-cycle output stall after the first five beats.
    base = n_emit;
    i = 0;
    while (i < 5) begin
      send32(sa[i], sb[i], sci[i], ssu[i], ref_add(32, {32'd0, sa[i]}, {32'd0, sb[i]}, sci[i], ssu[i]));
      i++;
    end
    bus32.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus32.in_valid = (i < 20);
      if (i < 20) begin
        bus32.A = sa[i]; bus32.B = sb[i]; bus32.Cin = sci[i]; bus32.Sub = ssu[i];
      end
      #4;
      check("stall_in_ready", {63'd0, bus32.in_ready}, {63'd0, (n_acc - n_emit) < 7});
      if (bus32.in_ready && bus32.in_valid) begin
        push32(ref_add(32, {32'd0, sa[i]}, {32'd0, sb[i]}, sci[i], ssu[i]));
        i++;
      end
      @(negedge clk);
    end
    #4;
    check("full_in_ready", {63'd0, bus32.in_ready}, 64'd0);
    check("held_beats", n_acc - n_emit, 7);
    @(negedge clk);
    bus32.out_ready = 1'b1;
    while (i < 20) begin
      send32(sa[i], sb[i], sci[i], ssu[i], ref_add(32, {32'd0, sa[i]}, {32'd0, sb[i]}, sci[i], ssu[i]));
      i++;
    end
    bus32.in_valid = 1'b0;
    drain32();
    check("stream_emitted", n_emit - base, 20);

    // Three beats in flight, then a one-cycle reset pulse discards them.
    for (int k = 0; k < 3; k++) begin
      send32(sa[k], sb[k], sci[k], ssu[k], ref_add(32, {32'd0, sa[k]}, {32'd0, sb[k]}, sci[k], ssu[k]));
    end
    bus32.in_valid = 1'b0;
    rst_n = 1'b0;
    exp32_q.delete();
    #4;
    check("pulse_in_ready", {63'd0, bus32.in_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #4;
      if (c == 0) check("post_rst_in_ready", {63'd0, bus32.in_ready}, 64'd1);
      check("post_rst_out_valid", {63'd0, bus32.out_valid}, 64'd0);
      check("post_rst_sum", {32'd0, bus32.Sum}, 64'd0);
      check("post_rst_cout_ovf", {62'd0, bus32.Cout, bus32.Ovf}, 64'd0);
      @(negedge clk);
    end

    for (int c = 0; c < 80000 && !(done8 && done24); c++) @(negedge clk);
    check("random_done", {62'd0, done8, done24}, 64'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
